// File: rtl/strobe_stretcher_pkg.sv
// Shared types and default widths for the strobe stretcher.
package strobe_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned PEND_W_DEF = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter holding the number of queued strobes.
module sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         sat
);

  assign sat = &count;

  // Count up/down; inc+dec cancels, inc at saturation and dec at zero are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && !sat) begin
      count <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/strobe_stretcher.sv
// Stretches single-cycle strobes into pulses of programmable length with a
// programmable minimum low gap; retrigger or queue mode.
module strobe_stretcher
  import strobe_stretcher_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned PEND_W = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  input  logic [CNT_W-1:0]  len,
  input  logic [CNT_W-1:0]  gap,
  input  logic              retrig,
  input  logic              clr_ovf,
  output logic              out,
  output logic              busy,
  output logic              done,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_m1;
  logic [CNT_W-1:0] gap_m1;
  logic             cnt_zero;
  logic             q_inc;
  logic             q_dec;
  logic             q_sat;
  logic             q_drop;

  // A zero length/gap behaves as one cycle, so reload value never wraps.
  assign len_m1   = (len == '0) ? '0 : len - 1'b1;
  assign gap_m1   = (gap == '0) ? '0 : gap - 1'b1;
  assign cnt_zero = (cnt == '0);

  // Strobes queue during a queue-mode pulse or any gap; the last gap cycle
  // consumes one (a same-cycle strobe and a consume cancel in the counter).
  assign q_inc  = in && (((state == ACTIVE) && !retrig) || (state == GAP));
  assign q_dec  = (state == GAP) && cnt_zero && ((pending != '0) || in);
  assign q_drop = q_inc && !q_dec && q_sat;

  sat_counter #(.W(PEND_W)) u_pend (
    .clk   (clk),
    .rst   (rst),
    .inc   (q_inc),
    .dec   (q_dec),
    .count (pending),
    .sat   (q_sat)
  );

  // Pulse/gap sequencing with registered out, busy, done and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      out      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (q_drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (in) begin
            state <= ACTIVE;
            cnt   <= len_m1;
            out   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (retrig && in) begin
            cnt <= len_m1;
          end else if (cnt_zero) begin
            state <= GAP;
            cnt   <= gap_m1;
            out   <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt_zero) begin
            if ((pending != '0) || in) begin
              state <= ACTIVE;
              cnt   <= len_m1;
              out   <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          out   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_strobe_stretcher.sv
// Self-checking bench: directed scenarios plus random strobes, compared every
// cycle against a behavioural model built on remaining-high/low cycle counts.
module tb_strobe_stretcher;

  localparam int CW   = 16;
  localparam int PW   = 2;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in = 1'b0;
  logic [CW-1:0] len = '0;
  logic [CW-1:0] gap = '0;
  logic          retrig = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          out;
  logic          busy;
  logic          done;
  logic [PW-1:0] pending;
  logic          overflow;

  strobe_stretcher #(.CNT_W(CW), .PEND_W(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .len      (len),
    .gap      (gap),
    .retrig   (retrig),
    .clr_ovf  (clr_ovf),
    .out      (out),
    .busy     (busy),
    .done     (done),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // model: cycles of high output left, cycles of low gap left, queued strobes
  int hi_left = 0;
  int lo_left = 0;
  int pend    = 0;
  bit m_ovf   = 0;
  bit m_done  = 0;

  int hi_seen   = 0;
  int done_seen = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    hi_left = 0; lo_left = 0; pend = 0; m_ovf = 0; m_done = 0;
  endtask

  task automatic queue_one(inout bit drop);
    if (pend < PMAX) pend++;
    else drop = 1;
  endtask

  task automatic model_step();
    int L;
    int G;
    bit drop;
    L = (len == 0) ? 1 : int'(len);
    G = (gap == 0) ? 1 : int'(gap);
    drop = 0;
    m_done = 0;
    if (hi_left > 0) begin
      if (in && !retrig) queue_one(drop);
      if (in && retrig) hi_left = L;
      else begin
        hi_left--;
        if (hi_left == 0) begin lo_left = G; m_done = 1; end
      end
    end else if (lo_left > 0) begin
      if (lo_left == 1 && (pend > 0 || in)) begin
        pend = pend + int'(in) - 1;
        lo_left = 0;
        hi_left = L;
      end else begin
        if (in) queue_one(drop);
        lo_left--;
      end
    end else if (in) begin
      hi_left = L;
    end
    if (drop) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
  endtask

  function automatic bit m_idle();
    return (hi_left == 0) && (lo_left == 0);
  endfunction

  task automatic cyc(input bit i, input bit c);
    in = i;
    clr_ovf = c;
    @(posedge clk);
    model_step();
    #1;
    chk("out",      int'(out),      int'(hi_left > 0));
    chk("busy",     int'(busy),     int'(!m_idle()));
    chk("done",     int'(done),     int'(m_done));
    chk("pending",  int'(pending),  pend);
    chk("overflow", int'(overflow), int'(m_ovf));
    if (out) hi_seen++;
    if (done) done_seen++;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (!m_idle() && n < 300) begin cyc(0, 0); n++; end
    chk({tag, "_drain"}, int'(m_idle()), 1);
    cyc(0, 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_out",  int'(out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pend", int'(pending), 0);
    chk("rst_ovf",  int'(overflow), 0);
    #19 rst = 1'b0;
    model_reset();

    // single pulse: 5 high, one done, then idle after the 3-cycle gap
    len = 5; gap = 3; retrig = 0;
    hi_seen = 0; done_seen = 0;
    cyc(1, 0);
    for (int k = 0; k < 10; k++) cyc(0, 0);
    chk("single_width", hi_seen, 5);
    chk("single_done", done_seen, 1);
    chk("single_idle", int'(busy), 0);

    // len=0/gap=0 behave as 1
    len = 0; gap = 0;
    hi_seen = 0;
    cyc(1, 0);
    drain("len0");
    chk("len0_width", hi_seen, 1);

    // retrigger extends to 6 cycles
    len = 4; gap = 2; retrig = 1;
    hi_seen = 0; done_seen = 0;
    cyc(1, 0); cyc(0, 0); cyc(1, 0);
    drain("retrig");
    chk("retrig_width", hi_seen, 6);
    chk("retrig_done", done_seen, 1);

    // queue: three 3-cycle pulses
    len = 3; gap = 2; retrig = 0;
    hi_seen = 0; done_seen = 0;
    cyc(1, 0); cyc(1, 0); cyc(1, 0);
    drain("queue");
    chk("queue_width", hi_seen, 9);
    chk("queue_done", done_seen, 3);

    // overflow: 5 strobes in one pulse, then clr_ovf with a new drop
    len = 8; gap = 2;
    done_seen = 0;
    for (int k = 0; k < 5; k++) cyc(1, 0);
    cyc(1, 1);
    chk("ovf_sticky", int'(overflow), 1);
    cyc(0, 1);
    chk("ovf_clr", int'(overflow), 0);
    drain("ovf");
    chk("ovf_pulses", done_seen, 4);

    // async reset in the middle of a pulse
    len = 8;
    cyc(1, 0); cyc(1, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out", int'(out), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_pend", int'(pending), 0);
    model_reset();
    #2 rst = 1'b0;
    hi_seen = 0;
    cyc(1, 0);
    drain("arst");
    chk("arst_width", hi_seen, 8);

    // random traffic, len/gap resampled mid-pulse too
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) len = CW'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) gap = CW'($urandom_range(0, 5));
      if (m_idle() && $urandom_range(0, 15) == 0) retrig = ~retrig;
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
    end
    drain("rand");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
